// File: rtl/fetch_queue_multi.sv
// rtl/fetch_queue_multi.sv - multi-lane fetch bundle queue between fetch and decode/issue
// Per-lane independent pop; an entry retires once every lane it carried has been consumed.
module fetch_queue_multi #(
  parameter int LANES  = 2,
  parameter int LANE_W = 1,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2,
  parameter int INFO_W = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic                      push_i,
  input  logic [31:0]               pc_in_i,
  input  logic [LANES-1:0]          mask_in_i,
  input  logic [32*LANES-1:0]       data_in_i,
  input  logic [INFO_W*LANES-1:0]   info_in_i,
  output logic                      accept_o,
  output logic [LANES-1:0]          valid_o,
  output logic [32*LANES-1:0]       pc_out_o,
  output logic [32*LANES-1:0]       data_out_o,
  output logic [INFO_W*LANES-1:0]   info_out_o,
  input  logic [LANES-1:0]          pop_i,
  output logic [ADDR_W:0]           level_o
);

  localparam int PC_HI_W = 32 - LANE_W - 2;
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]          count_q, count_d;
  logic [PC_HI_W-1:0]       pc_q   [DEPTH];
  logic [LANES-1:0]         lv_q   [DEPTH];
  logic [32*LANES-1:0]      data_q [DEPTH];
  logic [INFO_W*LANES-1:0]  info_q [DEPTH];

  logic                     empty, push_eff, retire;
  logic [LANES-1:0]         pop_eff, head_left;
  logic [LANE_W+1:0]        unused_pc_lo;

  // Lane PCs are rebuilt from the bundle-aligned upper bits, so the low bits are never stored.
  assign unused_pc_lo = pc_in_i[LANE_W+1:0];

  assign empty      = (count_q == '0);
  assign accept_o   = (count_q != FULL);
  assign valid_o    = empty ? '0 : lv_q[rd_ptr_q];
  assign data_out_o = data_q[rd_ptr_q];
  assign info_out_o = info_q[rd_ptr_q];
  assign level_o    = count_q;

  assign pop_eff   = pop_i & valid_o;
  assign head_left = lv_q[rd_ptr_q] & ~pop_eff;
  assign retire    = !empty && (head_left == '0);
  assign push_eff  = push_i && accept_o && (mask_in_i != '0);

  // Lane PCs read as zero while empty so the port is all-zero out of reset.
  for (genvar k = 0; k < LANES; k++) begin : g_lane_pc
    localparam logic [LANE_W-1:0] LIDX = LANE_W'(k);
    assign pc_out_o[32*k +: 32] = empty ? 32'h0 : {pc_q[rd_ptr_q], LIDX, 2'b00};
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q + ADDR_W'(retire);
    wr_ptr_d = wr_ptr_q + ADDR_W'(push_eff);
    count_d  = count_q;
    if (push_eff && !retire)
      count_d = count_q + (ADDR_W+1)'(1);
    else if (retire && !push_eff)
      count_d = count_q - (ADDR_W+1)'(1);
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        lv_q[i]   <= '0;
        data_q[i] <= '0;
        info_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (flush_i) begin
        for (int i = 0; i < DEPTH; i++) lv_q[i] <= '0;
      end else begin
        // Head and tail entries never coincide here: that would need a full queue, which blocks push.
        if (!empty) lv_q[rd_ptr_q] <= head_left;
        if (push_eff) begin
          lv_q[wr_ptr_q]   <= mask_in_i;
          pc_q[wr_ptr_q]   <= pc_in_i[31:LANE_W+2];
          data_q[wr_ptr_q] <= data_in_i;
          info_q[wr_ptr_q] <= info_in_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue_multi.sv
// tb/tb_fetch_queue_multi.sv - directed vector bench for fetch_queue_multi (2-lane and 4-lane builds)
module tb_fetch_queue_multi;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 2-lane, depth-4 instance
  logic         flush, push, accept;
  logic [31:0]  pc_in;
  logic [1:0]   mask, valid, pop;
  logic [63:0]  data_in, pc_out, data_out;
  logic [3:0]   info_in, info_out;
  logic [2:0]   level;

  fetch_queue_multi #(.LANES(2), .LANE_W(1), .DEPTH(4), .ADDR_W(2), .INFO_W(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .push_i(push), .pc_in_i(pc_in),
    .mask_in_i(mask), .data_in_i(data_in), .info_in_i(info_in), .accept_o(accept),
    .valid_o(valid), .pc_out_o(pc_out), .data_out_o(data_out), .info_out_o(info_out),
    .pop_i(pop), .level_o(level)
  );

  // 4-lane, depth-8 instance
  logic         flush4, push4, accept4;
  logic [31:0]  pc_in4;
  logic [3:0]   mask4, valid4, pop4;
  logic [127:0] data_in4, pc_out4, data_out4;
  logic [7:0]   info_in4, info_out4;
  logic [3:0]   level4;

  fetch_queue_multi #(.LANES(4), .LANE_W(2), .DEPTH(8), .ADDR_W(3), .INFO_W(2)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush4), .push_i(push4), .pc_in_i(pc_in4),
    .mask_in_i(mask4), .data_in_i(data_in4), .info_in_i(info_in4), .accept_o(accept4),
    .valid_o(valid4), .pc_out_o(pc_out4), .data_out_o(data_out4), .info_out_o(info_out4),
    .pop_i(pop4), .level_o(level4)
  );

  typedef struct {
    logic        push;
    logic        flush;
    logic [31:0] pc;
    logic [1:0]  mask;
    logic [63:0] data;
    logic [3:0]  info;
    logic [1:0]  pop;
    logic [1:0]  e_valid;
    logic [2:0]  e_level;
    logic        e_accept;
    logic [63:0] e_pc;
    logic [63:0] e_data;
    logic [3:0]  e_info;
  } vec_t;

  localparam logic [63:0] D1 = 64'h00B00093_00100013;
  localparam logic [63:0] D2 = 64'hAAAA0001_22220000;
  localparam logic [63:0] D3 = 64'h33331111_33330000;
  localparam logic [63:0] D4 = 64'h44441111_44440000;
  localparam logic [63:0] D5 = 64'h55551111_55550000;
  localparam logic [63:0] D6 = 64'h66661111_66660000;
  localparam logic [63:0] D7 = 64'h77771111_77770000;
  localparam logic [63:0] D8 = 64'h88881111_88880000;
  localparam logic [63:0] D9 = 64'h99991111_99990000;
  localparam logic [63:0] DA = 64'hAAAA1111_AAAA0000;

  vec_t vecs [21];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [127:0] mk_data4(input int i);
    logic [127:0] d;
    for (int k = 0; k < 4; k++) d[32*k +: 32] = {16'(i), 16'(k)};
    return d;
  endfunction

  function automatic logic [127:0] mk_pc4(input int i);
    logic [127:0] p;
    for (int k = 0; k < 4; k++) p[32*k +: 32] = 32'h0001_0000 + 32'(i) * 32'h10 + 32'(k) * 32'h4;
    return p;
  endfunction

  initial begin
    int h, n, lvl;
    //         push flush pc        mask  data info pop    e_valid lvl acc e_pc                    e_data e_info
    vecs[0]  = '{1'b1, 1'b0, 32'h1000, 2'b11, D1, 4'h9, 2'b00, 2'b11, 3'd1, 1'b1, 64'h00001004_00001000, D1, 4'h9};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,    2'b00, 64'h0, 4'h0, 2'b11, 2'b00, 3'd0, 1'b1, 64'h0, 64'h0, 4'h0};
    vecs[2]  = '{1'b1, 1'b0, 32'h2004, 2'b01, D2, 4'h6, 2'b00, 2'b01, 3'd1, 1'b1, 64'h00002004_00002000, D2, 4'h6};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,    2'b00, 64'h0, 4'h0, 2'b01, 2'b00, 3'd0, 1'b1, 64'h0, 64'h0, 4'h0};
    vecs[4]  = '{1'b1, 1'b0, 32'h3000, 2'b11, D3, 4'h3, 2'b00, 2'b11, 3'd1, 1'b1, 64'h00003004_00003000, D3, 4'h3};
    vecs[5]  = '{1'b1, 1'b0, 32'h4000, 2'b11, D4, 4'hC, 2'b10, 2'b01, 3'd2, 1'b1, 64'h00003004_00003000, D3, 4'h3};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,    2'b00, 64'h0, 4'h0, 2'b01, 2'b11, 3'd1, 1'b1, 64'h00004004_00004000, D4, 4'hC};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,    2'b00, 64'h0, 4'h0, 2'b00, 2'b11, 3'd1, 1'b1, 64'h00004004_00004000, D4, 4'hC};
    vecs[8]  = '{1'b1, 1'b0, 32'h5000, 2'b00, D5, 4'h5, 2'b00, 2'b11, 3'd1, 1'b1, 64'h00004004_00004000, D4, 4'hC};
    vecs[9]  = '{1'b1, 1'b0, 32'h5000, 2'b11, D5, 4'h5, 2'b00, 2'b11, 3'd2, 1'b1, 64'h00004004_00004000, D4, 4'hC};
    vecs[10] = '{1'b1, 1'b0, 32'h6000, 2'b11, D6, 4'h6, 2'b00, 2'b11, 3'd3, 1'b1, 64'h00004004_00004000, D4, 4'hC};
    vecs[11] = '{1'b1, 1'b0, 32'h7000, 2'b11, D7, 4'h7, 2'b00, 2'b11, 3'd4, 1'b0, 64'h00004004_00004000, D4, 4'hC};
    vecs[12] = '{1'b1, 1'b0, 32'h8000, 2'b11, D8, 4'h8, 2'b00, 2'b11, 3'd4, 1'b0, 64'h00004004_00004000, D4, 4'hC};
    vecs[13] = '{1'b1, 1'b0, 32'h8000, 2'b11, D8, 4'h8, 2'b11, 2'b11, 3'd3, 1'b1, 64'h00005004_00005000, D5, 4'h5};
    vecs[14] = '{1'b0, 1'b0, 32'h0,    2'b00, 64'h0, 4'h0, 2'b01, 2'b10, 3'd3, 1'b1, 64'h00005004_00005000, D5, 4'h5};
    vecs[15] = '{1'b1, 1'b1, 32'h9000, 2'b11, D9, 4'h9, 2'b11, 2'b00, 3'd0, 1'b1, 64'h0, 64'h0, 4'h0};
    vecs[16] = '{1'b1, 1'b0, 32'hA000, 2'b11, DA, 4'hA, 2'b00, 2'b11, 3'd1, 1'b1, 64'h0000A004_0000A000, DA, 4'hA};
    vecs[17] = '{1'b0, 1'b0, 32'h0,    2'b00, 64'h0, 4'h0, 2'b10, 2'b01, 3'd1, 1'b1, 64'h0000A004_0000A000, DA, 4'hA};
    vecs[18] = '{1'b0, 1'b0, 32'h0,    2'b00, 64'h0, 4'h0, 2'b10, 2'b01, 3'd1, 1'b1, 64'h0000A004_0000A000, DA, 4'hA};
    vecs[19] = '{1'b0, 1'b0, 32'h0,    2'b00, 64'h0, 4'h0, 2'b01, 2'b00, 3'd0, 1'b1, 64'h0, 64'h0, 4'h0};
    vecs[20] = '{1'b0, 1'b0, 32'h0,    2'b00, 64'h0, 4'h0, 2'b11, 2'b00, 3'd0, 1'b1, 64'h0, 64'h0, 4'h0};

    {flush, push, pc_in, mask, data_in, info_in, pop} = '0;
    {flush4, push4, pc_in4, mask4, data_in4, info_in4, pop4} = '0;

    // Reset state, held across a clock edge
    #12;
    chk("rst valid",  128'(valid),    128'(0));
    chk("rst level",  128'(level),    128'(0));
    chk("rst accept", 128'(accept),   128'(1));
    chk("rst data",   128'(data_out), 128'(0));
    chk("rst pc",     128'(pc_out),   128'(0));
    chk("rst info",   128'(info_out), 128'(0));
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      push = vecs[i].push; flush = vecs[i].flush; pc_in = vecs[i].pc;
      mask = vecs[i].mask; data_in = vecs[i].data; info_in = vecs[i].info; pop = vecs[i].pop;
      @(posedge clk); #1;
      chk($sformatf("row%0d valid", i),  128'(valid),  128'(vecs[i].e_valid));
      chk($sformatf("row%0d level", i),  128'(level),  128'(vecs[i].e_level));
      chk($sformatf("row%0d accept", i), 128'(accept), 128'(vecs[i].e_accept));
      if (vecs[i].e_valid != 2'b00) begin
        chk($sformatf("row%0d pc", i),   128'(pc_out),   128'(vecs[i].e_pc));
        chk($sformatf("row%0d data", i), 128'(data_out), 128'(vecs[i].e_data));
        chk($sformatf("row%0d info", i), 128'(info_out), 128'(vecs[i].e_info));
      end
    end

    // Asynchronous reset between clock edges
    push = 1'b1; flush = 1'b0; pc_in = 32'hB000; mask = 2'b11; data_in = D9; info_in = 4'hF; pop = 2'b00;
    @(posedge clk); #1;
    push = 1'b0;
    chk("pre-arst valid", 128'(valid), 128'(2'b11));
    #2 rst_n = 1'b0;
    #1;
    chk("arst valid",  128'(valid),    128'(0));
    chk("arst level",  128'(level),    128'(0));
    chk("arst accept", 128'(accept),   128'(1));
    chk("arst data",   128'(data_out), 128'(0));
    chk("arst pc",     128'(pc_out),   128'(0));
    chk("arst info",   128'(info_out), 128'(0));
    @(negedge clk) rst_n = 1'b1;

    // 4-lane build: lane PC reconstruction
    push4 = 1'b1; pc_in4 = 32'h3008; mask4 = 4'hF; data_in4 = mk_data4(99); info_in4 = 8'hA5;
    @(posedge clk); #1;
    push4 = 1'b0;
    chk("l4 pc",    pc_out4,          128'h0000300C_00003008_00003004_00003000);
    chk("l4 valid", 128'(valid4),     128'(4'hF));
    chk("l4 level", 128'(level4),     128'(1));
    chk("l4 data",  data_out4,        mk_data4(99));
    pop4 = 4'hF;
    @(posedge clk); #1;
    pop4 = 4'h0;
    chk("l4 drain level", 128'(level4), 128'(0));

    // 20 bundles through a depth-8 queue: 6 push-only, 14 push+pop, 6 pop-only
    h = 0; n = 0; lvl = 0;
    for (int c = 0; c < 26; c++) begin
      push4 = (c < 20); pop4 = (c >= 6) ? 4'hF : 4'h0;
      pc_in4 = 32'h0001_0000 + 32'(n) * 32'h10; mask4 = 4'hF; data_in4 = mk_data4(n); info_in4 = 8'(n);
      if (c >= 6) begin
        chk($sformatf("wrap c%0d valid", c), 128'(valid4), 128'(4'hF));
        chk($sformatf("wrap c%0d data", c),  data_out4,    mk_data4(h));
        chk($sformatf("wrap c%0d pc", c),    pc_out4,      mk_pc4(h));
        h++;
      end
      if (c < 20) n++;
      lvl = lvl + ((c < 20) ? 1 : 0) - ((c >= 6) ? 1 : 0);
      @(posedge clk); #1;
      chk($sformatf("wrap c%0d level", c), 128'(level4), 128'(lvl));
    end
    push4 = 1'b0; pop4 = 4'h0;
    chk("wrap end valid", 128'(valid4), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_queue_multi.md
Name: fetch_queue_multi

Overview:
- Parametrised successor to the dual-issue fetch FIFO. It sits between the fetch unit and the decode/issue stage.
- Buffers fetch bundles of LANES 32-bit instructions, with a configurable depth and per-lane sideband info.
- Each lane is popped independently. A per-lane valid mask on push marks which lanes of a bundle exist.
- Provides a true flush that clears all per-lane valid state, plus an occupancy output.

Parameters:
- LANES, 2: instructions per bundle; power of 2, >= 2.
- LANE_W, 1: log2(LANES).
- DEPTH, 4: bundle entries; power of 2, >= 2.
- ADDR_W, 2: log2(DEPTH).
- INFO_W, 2: sideband bits per lane (e.g. {fault_page, fault_fetch}).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  branch redirect; discards all contents.
- push_i  in  1  bundle offered this cycle.
- pc_in_i  in  32  fetch PC of the bundle.
- mask_in_i  in  LANES  per-lane valid mask of the pushed bundle.
- data_in_i  in  32*LANES  instructions; lane k at bits [32k+31:32k].
- info_in_i  in  INFO_W*LANES  per-lane sideband, packed like data_in_i.
- accept_o  out  1  queue can take a bundle this cycle.
- valid_o  out  LANES  per-lane valid of the head bundle.
- pc_out_o  out  32*LANES  per-lane PC of the head bundle.
- data_out_o  out  32*LANES  per-lane instruction of the head bundle.
- info_out_o  out  INFO_W*LANES  per-lane sideband of the head bundle.
- pop_i  in  LANES  per-lane consume.
- level_o  out  ADDR_W+1  number of bundles held, 0..DEPTH.

Behaviour:
- Reset (rst_ni low, asynchronous): clears pointers, count, every entry's lane-valid bits, data, pc and info.
  - Outputs during and after reset: accept_o=1, valid_o=0, level_o=0, data/pc/info outputs=0.
  - Asserting reset mid-operation discards everything immediately, without waiting for a clock edge.
- Storage: DEPTH entries, each holding pc, LANES x (valid, data, info). Read pointer, write pointer and count are ADDR_W, ADDR_W and ADDR_W+1 bits; pointers wrap modulo DEPTH.
- accept_o = (count != DEPTH). It depends only on registered count; a retire in the same cycle does not free space for a push.
- Effective push = push_i & accept_o & (mask_in_i != 0).
  - An all-zero mask is dropped: no write and no pointer change. accept_o still reads as normal.
  - On an effective push, the entry at wr_ptr is written with mask_in_i as its lane valids, and wr_ptr increments.
- Head outputs are combinational from the rd_ptr entry, gated by count != 0.
  - valid_o[k] = (count != 0) & lane_valid[rd_ptr][k].
  - data_out_o and info_out_o are the stored values, unmasked.
- Lane PC: pc_out_o lane k = {pc[31:LANE_W+2], k[LANE_W-1:0], 2'b00}.
- Latency: a pushed bundle is visible on valid_o the cycle after the push edge. There is no bypass path.
- Pop:
  - Effective pop for lane k = pop_i[k] & valid_o[k]; it clears lane_valid[rd_ptr][k] at the edge.
  - pop_i on an invalid lane, or when empty, is ignored.
- Retire: the entry retires when (lane_valid[rd_ptr] & ~effective_pop) == 0 and count != 0. Partial pops accumulate across cycles.
  - On retire: rd_ptr increments.
- Count and level:
  - count +1 on push without retire; -1 on retire without push; unchanged when both or neither occur.
  - level_o = count.
- Flush (synchronous, highest priority after reset):
  - count, rd_ptr and wr_ptr go to 0, and all lane valids go to 0.
  - A push or pop in the same cycle is ignored. valid_o=0 on the following cycle.
- Full and empty:
  - Full (count=DEPTH): accept_o=0 and push_i is ignored.
  - Empty (count=0): valid_o=0 regardless of stale lane bits.
- Wrap: the pointers roll DEPTH-1 -> 0 with no bubble.

Test Plan:
- Reset then push pc=0x1000, mask=2'b11, data={0x00B00093,0x00100013}:
  - Next cycle: valid_o=11, pc lanes = 0x1000 and 0x1004, level_o=1.
  - pop_i=11: level_o=0 and valid_o=00 next cycle.
- Push pc=0x2004 with mask=01, then pop_i=01:
  - Lane1 is never valid.
  - Entry retires on the lane-0 pop, and rd_ptr advances.
- Split pop of mask=11 (DEPTH=4):
  - pop_i=10: valid_o becomes 01, level unchanged.
  - Next cycle pop_i=01: retire, level -1.
  - A second bundle behind it appears on valid_o the following cycle.
- Fill 4 bundles with no pops:
  - accept_o=0 and level_o=4; a 5th push is ignored.
  - pop_i=11 and push together: retire only, level_o=3, accept_o=1 next cycle.
- At level_o=3 with the head partially popped: flush_i together with push_i and pop_i=11:
  - Next cycle: level_o=0, valid_o=00, accept_o=1.
  - Next push after that appears with a full mask, with no stale lanes.
- Mid-stream deassert rst_ni between clock edges: valid_o, level_o and the data outputs go to 0 immediately.
- Push with mask=00: level_o stays unchanged.
- LANES=4, LANE_W=2, DEPTH=8 run:
  - Push pc=0x3008, mask=1111: lane PCs are 0x3000, 0x3004, 0x3008, 0x300C.
  - 20 pushes and pops wrap the pointers with no loss.
